control_pipe: RTL and testbench

Registered, parametrised instruction-control stage that replaces the purely combinational decoder between fetch and execute. It decodes one opcode per accepted beat using the existing class/sub-op encoding and registers all control outputs behind a valid/ready handshake. It adds multi-beat sequencing for PUSH/POP, pipeline flush, and an explicit illegal-opcode flag in place of stale or latched outputs.

---
 rtl/control_pipe.sv | 183 ++++++++++++++++++
 tb/tb_control_pipe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// Registered instruction-control stage: decodes one opcode per accepted beat and
// sequences PUSH/POP over several output beats. Optional counters: CONTROL_PIPE_PERF_EN.
module control_pipe #(
    parameter int SHIFT_W     = 5,
    parameter int ALU_OP_W    = 4,
    parameter int STACK_BEATS = 2
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                inValid,
    output logic                inReady,
    input  logic [5:0]          opcode,
    input  logic [SHIFT_W-1:0]  shiftIn,
    input  logic                immSelect,
    input  logic                flush,
    output logic                outValid,
    input  logic                outReady,
    output logic [ALU_OP_W-1:0] aluOp,
    output logic [SHIFT_W-1:0]  shiftOut,
    output logic                load,
    output logic                store,
    output logic                push,
    output logic                pop,
    output logic                reti,
    output logic                shiftReg,
    output logic                branch,
    output logic                noFlush,
    output logic                addCalcSelectA,
    output logic [2:0]          branchMode,
    output logic [2:0]          stackBeat,
    output logic                illegal
`ifdef CONTROL_PIPE_PERF_EN
    ,
    output logic [15:0]         issuedCount,
    output logic [15:0]         stallCount
`endif
);

    localparam logic [2:0] LAST_BEAT = 3'(STACK_BEATS - 1);

    typedef enum logic [1:0] {EMPTY, HOLD, SEQ} state_t;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [SHIFT_W-1:0]  shift;
        logic                load;
        logic                store;
        logic                push;
        logic                pop;
        logic                reti;
        logic                shift_reg;
        logic                branch;
        logic                no_flush;
        logic                add_calc;
        logic [2:0]          branch_mode;
        logic                illegal;
    } ctl_t;

    ctl_t   dec_p0;
    ctl_t   ctl_p1;
    state_t state_p1, state_nxt;
    logic [2:0] beat_p1, beat_nxt;
    logic   vld_p1;
    logic   last_beat;
    logic   accept;
    logic   load_ctl;
    logic   clear_ctl;

    // Stage 0: combinational decode of the offered opcode
    always_comb begin
        dec_p0 = '0;
        case (opcode[5:4])
            2'b00: begin
                dec_p0.alu_op = ALU_OP_W'(opcode[3:0]);
                dec_p0.shift  = immSelect ? '0 : shiftIn;
            end
            2'b10: begin
                case (opcode[3:0])
                    4'b0000: dec_p0.load = 1'b1;
                    4'b0001: dec_p0.store = 1'b1;
                    4'b0100: begin
                        dec_p0.shift_reg = 1'b1;
                        dec_p0.shift     = {shiftIn[SHIFT_W-1], {(SHIFT_W-1){1'b0}}};
                    end
                    4'b0011: dec_p0.push = 1'b1;
                    4'b0010: begin
                        dec_p0.pop  = 1'b1;
                        dec_p0.load = 1'b1;
                    end
                    4'b0111: begin
                        dec_p0.reti        = 1'b1;
                        dec_p0.branch      = 1'b1;
                        dec_p0.branch_mode = opcode[2:0];
                    end
                    default: dec_p0.illegal = 1'b1;
                endcase
            end
            default: begin
                dec_p0.branch      = 1'b1;
                dec_p0.branch_mode = opcode[2:0];
                dec_p0.add_calc    = opcode[3];
                dec_p0.no_flush    = opcode[5];
            end
        endcase
    end

    assign vld_p1    = (state_p1 != EMPTY);
    assign last_beat = (state_p1 == HOLD) || (state_p1 == SEQ && beat_p1 == LAST_BEAT);
    assign inReady   = !vld_p1 || (outReady && last_beat);
    assign accept    = inValid && inReady;

    // A protected (noFlush) op in HOLD ignores flush and keeps normal handshaking
    always_comb begin
        state_nxt = state_p1;
        beat_nxt  = beat_p1;
        load_ctl  = 1'b0;
        clear_ctl = 1'b0;
        if (flush && !(state_p1 == HOLD && ctl_p1.no_flush)) begin
            state_nxt = EMPTY;
            beat_nxt  = '0;
            clear_ctl = 1'b1;
        end else if (!vld_p1 || (outReady && last_beat)) begin
            if (accept) begin
                state_nxt = (dec_p0.push || dec_p0.pop) ? SEQ : HOLD;
                beat_nxt  = '0;
                load_ctl  = 1'b1;
            end else begin
                state_nxt = EMPTY;
                beat_nxt  = '0;
                clear_ctl = 1'b1;
            end
        end else if (outReady) begin
            beat_nxt = beat_p1 + 3'd1;
        end
    end

    // Stage 1: registered controls
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_p1 <= EMPTY;
            beat_p1  <= '0;
            ctl_p1   <= '0;
        end else begin
            state_p1 <= state_nxt;
            beat_p1  <= beat_nxt;
            if (load_ctl)
                ctl_p1 <= dec_p0;
            else if (clear_ctl)
                ctl_p1 <= '0;
        end
    end

`ifdef CONTROL_PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstN) begin
            issuedCount <= '0;
            stallCount  <= '0;
        end else begin
            if (vld_p1 && outReady)
                issuedCount <= issuedCount + 16'd1;
            if (vld_p1 && !outReady && stallCount != 16'hFFFF)
                stallCount <= stallCount + 16'd1;
        end
    end
`endif

    assign outValid       = vld_p1;
    assign aluOp          = ctl_p1.alu_op;
    assign shiftOut       = ctl_p1.shift;
    assign load           = ctl_p1.load;
    assign store          = ctl_p1.store;
    assign push           = ctl_p1.push;
    assign pop            = ctl_p1.pop;
    assign reti           = ctl_p1.reti;
    assign shiftReg       = ctl_p1.shift_reg;
    assign branch         = ctl_p1.branch;
    assign noFlush        = ctl_p1.no_flush;
    assign addCalcSelectA = ctl_p1.add_calc;
    assign branchMode     = ctl_p1.branch_mode;
    assign stackBeat      = beat_p1;
    assign illegal        = ctl_p1.illegal;

endmodule

// File: tb/tb_control_pipe.sv
// Directed self-checking bench for control_pipe (default parameters).
module tb_control_pipe;

    logic       clk = 1'b0;
    logic       rstN, inValid, inReady, immSelect, flush, outValid, outReady;
    logic [5:0] opcode;
    logic [4:0] shiftIn, shiftOut;
    logic [3:0] aluOp;
    logic       load, store, push, pop, reti, shiftReg, branch, noFlush, addCalcSelectA, illegal;
    logic [2:0] branchMode, stackBeat;
    logic [9:0] strobes;
`ifdef CONTROL_PIPE_PERF_EN
    logic [15:0] issuedCount, stallCount;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // load store push pop reti shiftReg branch noFlush addCalcSelectA illegal
    assign strobes = {load, store, push, pop, reti, shiftReg, branch, noFlush, addCalcSelectA, illegal};

    control_pipe dut (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
        .opcode(opcode), .shiftIn(shiftIn), .immSelect(immSelect), .flush(flush),
        .outValid(outValid), .outReady(outReady), .aluOp(aluOp), .shiftOut(shiftOut),
        .load(load), .store(store), .push(push), .pop(pop), .reti(reti),
        .shiftReg(shiftReg), .branch(branch), .noFlush(noFlush),
        .addCalcSelectA(addCalcSelectA), .branchMode(branchMode),
        .stackBeat(stackBeat), .illegal(illegal)
`ifdef CONTROL_PIPE_PERF_EN
        , .issuedCount(issuedCount), .stallCount(stallCount)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstN = 1'b0; inValid = 1'b0; opcode = '0; shiftIn = '0;
        immSelect = 1'b0; flush = 1'b0; outReady = 1'b1;
        step(); step();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %0h exp 0", outValid); end
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %0h exp 1", inReady); end
        checks++; if ({aluOp, shiftOut, branchMode, stackBeat, strobes} !== '0) begin errors++;
            $display("FAIL reset_controls got %0h exp 0", {aluOp, shiftOut, branchMode, stackBeat, strobes}); end
    endtask

    task automatic test_rtype();
        inValid = 1'b1; opcode = 6'b000101; shiftIn = 5'd9; immSelect = 1'b0;
        step();
        checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL rtype_valid got %0h exp 1", outValid); end
        checks++; if (aluOp !== 4'b0101) begin errors++; $display("FAIL rtype_aluOp got %0h exp 5", aluOp); end
        checks++; if (shiftOut !== 5'd9) begin errors++; $display("FAIL rtype_shift got %0d exp 9", shiftOut); end
        checks++; if (strobes !== 10'b0) begin errors++; $display("FAIL rtype_strobes got %b exp 0", strobes); end
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL rtype_inReady got %0h exp 1", inReady); end
        immSelect = 1'b1;
        step();
        inValid = 1'b0; immSelect = 1'b0;
        checks++; if (shiftOut !== 5'd0 || aluOp !== 4'b0101 || outValid !== 1'b1) begin errors++;
            $display("FAIL rtype_imm got shift %0d alu %0h vld %0h exp 0 5 1", shiftOut, aluOp, outValid); end
        step();
        checks++; if (outValid !== 1'b0 || aluOp !== 4'd0) begin errors++;
            $display("FAIL rtype_drain got vld %0h alu %0h exp 0 0", outValid, aluOp); end
    endtask

    task automatic test_push_back_to_back();
        inValid = 1'b1; opcode = 6'b100011;
        step();
        inValid = 1'b0;
        checks++; if (strobes !== 10'b0010000000 || stackBeat !== 3'd0 || inReady !== 1'b0) begin errors++;
            $display("FAIL push_beat0 got %b beat %0d rdy %0h exp 0010000000 0 0", strobes, stackBeat, inReady); end
        step();
        checks++; if (strobes !== 10'b0010000000 || stackBeat !== 3'd1 || inReady !== 1'b1 || outValid !== 1'b1) begin errors++;
            $display("FAIL push_beat1 got %b beat %0d rdy %0h vld %0h exp 0010000000 1 1 1", strobes, stackBeat, inReady, outValid); end
        inValid = 1'b1; opcode = 6'b100000;
        step();
        inValid = 1'b0;
        checks++; if (strobes !== 10'b1000000000 || stackBeat !== 3'd0 || outValid !== 1'b1) begin errors++;
            $display("FAIL push_then_load got %b beat %0d vld %0h exp 1000000000 0 1", strobes, stackBeat, outValid); end
        step();
    endtask

    task automatic test_pop_stall();
        do_reset();
        inValid = 1'b1; opcode = 6'b100010;
        step();
        inValid = 1'b0; outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (strobes !== 10'b1001000000 || stackBeat !== 3'd0 || inReady !== 1'b0 || outValid !== 1'b1) begin errors++;
                $display("FAIL pop_stall%0d got %b beat %0d rdy %0h exp 1001000000 0 0", i, strobes, stackBeat, inReady); end
        end
`ifdef CONTROL_PIPE_PERF_EN
        checks++; if (stallCount !== 16'd3) begin errors++; $display("FAIL pop_stallCount got %0d exp 3", stallCount); end
`endif
        outReady = 1'b1;
        step();
        checks++; if (stackBeat !== 3'd1 || pop !== 1'b1) begin errors++;
            $display("FAIL pop_beat1 got beat %0d pop %0h exp 1 1", stackBeat, pop); end
        step();
        checks++; if (outValid !== 1'b0 || stackBeat !== 3'd0 || strobes !== 10'b0) begin errors++;
            $display("FAIL pop_drain got vld %0h beat %0d strobes %b exp 0 0 0", outValid, stackBeat, strobes); end
    endtask

    task automatic test_flush();
        inValid = 1'b1; opcode = 6'b011010;
        step();
        checks++; if (strobes !== 10'b0000001010 || branchMode !== 3'b010) begin errors++;
            $display("FAIL br01_decode got %b mode %0d exp 0000001010 2", strobes, branchMode); end
        // a beat offered alongside flush is dropped
        opcode = 6'b000001; flush = 1'b1;
        step();
        inValid = 1'b0; flush = 1'b0;
        checks++; if (outValid !== 1'b0 || strobes !== 10'b0 || aluOp !== 4'd0) begin errors++;
            $display("FAIL br01_flush got vld %0h strobes %b alu %0h exp 0 0 0", outValid, strobes, aluOp); end
        inValid = 1'b1; opcode = 6'b111010;
        step();
        inValid = 1'b0; outReady = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (outValid !== 1'b1 || strobes !== 10'b0000001110 || branchMode !== 3'b010) begin errors++;
            $display("FAIL br11_flush got vld %0h strobes %b mode %0d exp 1 0000001110 2", outValid, strobes, branchMode); end
        outReady = 1'b1;
        step();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL br11_drain got %0h exp 0", outValid); end
    endtask

    task automatic test_illegal_reti();
        inValid = 1'b1; opcode = 6'b101010;
        step();
        checks++; if (outValid !== 1'b1 || strobes !== 10'b0000000001 || aluOp !== 4'd0 || shiftOut !== 5'd0) begin errors++;
            $display("FAIL illegal got vld %0h strobes %b alu %0h exp 1 0000000001 0", outValid, strobes, aluOp); end
        opcode = 6'b100111;
        step();
        checks++; if (strobes !== 10'b0000101000 || branchMode !== 3'b111) begin errors++;
            $display("FAIL reti got %b mode %0d exp 0000101000 7", strobes, branchMode); end
        opcode = 6'b100100; shiftIn = 5'b10110;
        step();
        checks++; if (strobes !== 10'b0000010000 || shiftOut !== 5'b10000) begin errors++;
            $display("FAIL shiftreg got %b shift %b exp 0000010000 10000", strobes, shiftOut); end
        opcode = 6'b100001;
        step();
        inValid = 1'b0;
        checks++; if (strobes !== 10'b0100000000 || shiftOut !== 5'd0) begin errors++;
            $display("FAIL store got %b shift %b exp 0100000000 0", strobes, shiftOut); end
        step();
    endtask

    task automatic test_reset_mid_seq();
        inValid = 1'b1; opcode = 6'b100011;
        step();
        inValid = 1'b0;
        step();
        outReady = 1'b0;
        checks++; if (stackBeat !== 3'd1) begin errors++; $display("FAIL midseq_beat got %0d exp 1", stackBeat); end
        rstN = 1'b0;
        step();
        rstN = 1'b1; outReady = 1'b1;
        checks++; if (outValid !== 1'b0 || stackBeat !== 3'd0 || inReady !== 1'b1 || strobes !== 10'b0) begin errors++;
            $display("FAIL midseq_reset got vld %0h beat %0d rdy %0h strobes %b exp 0 0 1 0", outValid, stackBeat, inReady, strobes); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_push_back_to_back();
        test_pop_stall();
        test_flush();
        test_illegal_reti();
        test_reset_mid_seq();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
